rpsc_fault_latch: RTL and testbench
===================================

RPSC_FAULT_LATCH -- requirements
Module: rpsc_fault_latch

Interface
REQ-001 Parameter DEBOUNCE, 4: consecutive synchronized-active cycles needed to qualify a fault (range 1-15).
REQ-002 Parameter CLR_TIMEOUT, 16: maximum RESET_WAIT duration in cycles (range 2-255).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fault_in_b  input  7  raw asynchronous interlock inputs, active-low.
REQ-007 ack  input  1  operator fault-reset request, level, synchronous to clk.
REQ-008 ff_out  output  7  latched faults, active-high. Bit map: 0 ff1_pin6, 1 ff2, 2 ff3_pin10, 3 ff4, 4 ff6, 5 ff1_pin50, 6 ff3_pin51.
REQ-009 perm_fault  output  1  OR of ff_out[4:0], RF-permit group.
REQ-010 red_fault  output  1  OR of ff_out[6:5], RF-reduce group.
REQ-011 alarm_b  output  1  low while any ff_out bit is set.
REQ-012 first_fault  output  3  index of first latched channel.
REQ-013 first_valid  output  1  first_fault holds a valid index.
REQ-014 trip_count  output  8  saturating trip counter.
REQ-015 ack_timeout  output  1  one-cycle pulse on abandoned reset.
REQ-016 state  output  2  0 ARMED, 1 TRIPPED, 2 RESET_WAIT.

Function
REQ-017 Each fault_in_b bit SHALL pass a 2-flop synchronizer; sync2 is the synchronized value.
REQ-018 Per channel, a 4-bit debounce counter SHALL increment while sync2=0, saturate at DEBOUNCE, and clear to 0 on any cycle sync2=1.
REQ-019 A channel qualifies on the edge its counter reaches DEBOUNCE; ff_out[i] SHALL set on that edge: input sampled low at edge k and held -> ff_out[i]=1 after edge k+1+DEBOUNCE.
REQ-020 A low pulse shorter than DEBOUNCE cycles at sync2 SHALL never set ff_out.
REQ-021 ff_out bits SHALL be sticky, cleared only by the clear action (REQ-026) or reset.
REQ-022 perm_fault, red_fault, alarm_b SHALL be combinational from registered ff_out (same-cycle).
REQ-023 ARMED -> TRIPPED on the edge any channel qualifies; trip_count +1 on that transition only, saturating at 255.
REQ-024 On that transition, first_fault = lowest index among channels qualifying that edge; first_valid=1; both held until clear.
REQ-025 Qualifications in TRIPPED/RESET_WAIT SHALL set ff_out but not change first_fault, trip_count or state.
REQ-026 Clear action: all ff_out, first_fault=0, first_valid=0, state -> ARMED, on one edge.
REQ-027 ack rising edge (ack=1, previous ack=0) in TRIPPED: if all sync2=1 and all counters 0, clear action that edge; otherwise -> RESET_WAIT, timeout counter loaded 0.
REQ-028 RESET_WAIT: clear action on the first edge where all sync2=1 and all counters 0; timeout counter increments each cycle.
REQ-029 RESET_WAIT, timeout counter reaching CLR_TIMEOUT with clear condition false -> TRIPPED, ack_timeout=1 for exactly one cycle, ff_out unchanged.
REQ-030 Clear condition and timeout on same edge: clear wins, no ack_timeout.
REQ-031 ack in ARMED or RESET_WAIT SHALL be ignored; ack held high SHALL not retrigger.
REQ-032 All outputs except REQ-022 signals SHALL be registered.

Reset
REQ-033 reset=1 at an edge, in any state: ff_out=0, first_fault=0, first_valid=0, trip_count=0, ack_timeout=0, state=ARMED, counters 0, synchronizer flops and previous-ack set to inactive (1 and 0); hence alarm_b=1, perm_fault=red_fault=0.
REQ-034 Reset SHALL override every concurrent qualification or ack.

Verification
REQ-035 Reset 2 cycles, fault_in_b=7'h7F -> ff_out=0, alarm_b=1, state=0, trip_count=0.
REQ-036 fault_in_b[3] low 3 cycles then high -> no latch; then low held -> ff_out=7'h08 after edge k+5, first_fault=3, first_valid=1, perm_fault=1, trip_count=1.
REQ-037 fault_in_b[6] and [1] low same edge -> ff_out=7'h42, first_fault=1, perm_fault=1, red_fault=1, alarm_b=0.
REQ-038 ack pulse with fault_in_b[3] still low -> state=2; release input -> clear on first edge its sync2=1 and counter=0, state=0, trip_count stays 1.
REQ-039 ack with input held low 16+ cycles -> ack_timeout pulses 1 cycle, state=1, ff_out unchanged.
REQ-040 reset asserted in RESET_WAIT with faults active -> all outputs at REQ-033 values after that edge.

Source files
------------

// File: rtl/rpsc_fault_latch_if.sv
// ---------------------------------------------------------------------------
// rpsc_fault_latch_if: interlock inputs and latched-fault status bundle. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rpsc_fault_latch_if;
  logic [6:0] fault_in_b;
  logic       ack;
  logic [6:0] ff_out;
  logic       perm_fault;
  logic       red_fault;
  logic       alarm_b;
  logic [2:0] first_fault;
  logic       first_valid;
  logic [7:0] trip_count;
  logic       ack_timeout;
  logic [1:0] state;

  modport slave (
    input  fault_in_b, ack,
    output ff_out, perm_fault, red_fault, alarm_b, first_fault,
           first_valid, trip_count, ack_timeout, state
  );

  modport master (
    output fault_in_b, ack,
    input  ff_out, perm_fault, red_fault, alarm_b, first_fault,
           first_valid, trip_count, ack_timeout, state
  );
endinterface

`default_nettype wire

// File: rtl/rpsc_fault_latch.sv
// ---------------------------------------------------------------------------
// rpsc_fault_latch: debounced sticky interlock latch with first-fault capture. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rpsc_fault_latch #(
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned CLR_TIMEOUT = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  rpsc_fault_latch_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ARMED      = 2'd0,
    ST_TRIPPED    = 2'd1,
    ST_RESET_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] c_deb      = 4'(DEBOUNCE);
  localparam logic [3:0] c_deb_last = 4'(DEBOUNCE - 1);
  localparam logic [7:0] c_tmo_last = 8'(CLR_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [6:0] sync1_q, sync2_q;
  logic [3:0] cnt_q [7];
  logic [3:0] cnt_d [7];
  logic [6:0] ff_q, ff_d;
  logic [2:0] first_q, first_d;
  logic       fv_q, fv_d;
  logic [7:0] tc_q, tc_d;
  logic [7:0] to_q, to_d;
  logic       at_q, at_d;
  logic       ack_prev_q;

  logic [6:0] qual;
  logic       cnt_zero;
  logic       clr_ok;
  logic       ack_rise;
  logic       do_clear;

  // Per-channel debounce; a channel qualifies on the edge its count reaches DEBOUNCE.
  always_comb begin
    cnt_zero = 1'b1;
    qual     = '0;
    for (int i = 0; i < 7; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i])
        cnt_d[i] = '0;
      else if (cnt_q[i] != c_deb)
        cnt_d[i] = cnt_q[i] + 4'd1;
      qual[i] = ~sync2_q[i] && (cnt_q[i] == c_deb_last);
      if (cnt_q[i] != 4'd0)
        cnt_zero = 1'b0;
    end
  end

  assign clr_ok   = (&sync2_q) && cnt_zero;
  assign ack_rise = bus.ack && !ack_prev_q;

  always_comb begin
    state_d  = state_q;
    ff_d     = ff_q | qual;
    first_d  = first_q;
    fv_d     = fv_q;
    tc_d     = tc_q;
    to_d     = to_q;
    at_d     = 1'b0;
    do_clear = 1'b0;

    case (state_q)
      ST_ARMED: begin
        if (|qual) begin
          state_d = ST_TRIPPED;
          fv_d    = 1'b1;
          for (int i = 6; i >= 0; i--)
            if (qual[i]) first_d = 3'(i);
          if (tc_q != 8'hFF)
            tc_d = tc_q + 8'd1;
        end
      end
      ST_TRIPPED: begin
        if (ack_rise) begin
          if (clr_ok) begin
            do_clear = 1'b1;
          end else begin
            state_d = ST_RESET_WAIT;
            to_d    = '0;
          end
        end
      end
      ST_RESET_WAIT: begin
        // Clear takes priority over an expiring timeout on the same edge.
        if (clr_ok) begin
          do_clear = 1'b1;
        end else if (to_q == c_tmo_last) begin
          state_d = ST_TRIPPED;
          at_d    = 1'b1;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      default: state_d = ST_ARMED;
    endcase

    if (do_clear) begin
      ff_d    = '0;
      first_d = '0;
      fv_d    = 1'b0;
      state_d = ST_ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARMED;
      sync1_q    <= '1;
      sync2_q    <= '1;
      ff_q       <= '0;
      first_q    <= '0;
      fv_q       <= 1'b0;
      tc_q       <= '0;
      to_q       <= '0;
      at_q       <= 1'b0;
      ack_prev_q <= 1'b0;
      for (int i = 0; i < 7; i++)
        cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= bus.fault_in_b;
      sync2_q    <= sync1_q;
      ff_q       <= ff_d;
      first_q    <= first_d;
      fv_q       <= fv_d;
      tc_q       <= tc_d;
      to_q       <= to_d;
      at_q       <= at_d;
      ack_prev_q <= bus.ack;
      for (int i = 0; i < 7; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.ff_out      = ff_q;
  assign bus.perm_fault  = |ff_q[4:0];
  assign bus.red_fault   = |ff_q[6:5];
  assign bus.alarm_b     = ~(|ff_q);
  assign bus.first_fault = first_q;
  assign bus.first_valid = fv_q;
  assign bus.trip_count  = tc_q;
  assign bus.ack_timeout = at_q;
  assign bus.state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_rpsc_fault_latch.sv
// ---------------------------------------------------------------------------
// tb_rpsc_fault_latch: scenario bench for rpsc_fault_latch with expectation queue. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rpsc_fault_latch;

  typedef struct packed {
    logic [6:0] ff;
    logic       perm;
    logic       red;
    logic       alarm_b;
    logic [2:0] first;
    logic       fv;
    logic [7:0] tc;
    logic       at;
    logic [1:0] st;
  } obs_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  obs_t sb[$];
  obs_t obs;
  obs_t exp_v;

  rpsc_fault_latch_if bus ();

  rpsc_fault_latch #(.DEBOUNCE(4), .CLR_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [6:0] ff, input logic [2:0] first,
                              input logic fv, input logic [7:0] tc,
                              input logic at, input logic [1:0] st);
    obs_t o;
    o.ff      = ff;
    o.perm    = |ff[4:0];
    o.red     = |ff[6:5];
    o.alarm_b = (ff == 7'h00);
    o.first   = first;
    o.fv      = fv;
    o.tc      = tc;
    o.at      = at;
    o.st      = st;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ff      = bus.ff_out;
    o.perm    = bus.perm_fault;
    o.red     = bus.red_fault;
    o.alarm_b = bus.alarm_b;
    o.first   = bus.first_fault;
    o.fv      = bus.first_valid;
    o.tc      = bus.trip_count;
    o.at      = bus.ack_timeout;
    o.st      = bus.state;
    return o;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.fault_in_b = 7'h7F; bus.ack = 1'b0;
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd0, 1'b0, 2'd0));
    tick(2);
    reset = 1'b0;
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd0, 1'b0, 2'd0));
    tick(3);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_debounce();
    bus.fault_in_b[3] = 1'b0;
    tick(3);
    bus.fault_in_b[3] = 1'b1;
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd0, 1'b0, 2'd0));
    tick(8);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL short_glitch: got %h want %h", obs, exp_v); end
    bus.fault_in_b[3] = 1'b0;
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd0, 1'b0, 2'd0));
    sb.push_back(mk(7'h08, 3'd3, 1'b1, 8'd1, 1'b0, 2'd1));
    tick(5);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL debounce_early: got %h want %h", obs, exp_v); end
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL debounce_latch: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_ack_wait();
    bus.ack = 1'b1;
    sb.push_back(mk(7'h08, 3'd3, 1'b1, 8'd1, 1'b0, 2'd2));
    tick(1);
    bus.ack = 1'b0;
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ack_enter_wait: got %h want %h", obs, exp_v); end
    bus.fault_in_b[3] = 1'b1;
    sb.push_back(mk(7'h08, 3'd3, 1'b1, 8'd1, 1'b0, 2'd2));
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd1, 1'b0, 2'd0));
    tick(3);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wait_hold: got %h want %h", obs, exp_v); end
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wait_clear: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_simultaneous();
    bus.fault_in_b[6] = 1'b0;
    bus.fault_in_b[1] = 1'b0;
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd1, 1'b0, 2'd0));
    sb.push_back(mk(7'h42, 3'd1, 1'b1, 8'd2, 1'b0, 2'd1));
    tick(5);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL simul_early: got %h want %h", obs, exp_v); end
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL simul_latch: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_timeout();
    bus.ack = 1'b1;
    sb.push_back(mk(7'h42, 3'd1, 1'b1, 8'd2, 1'b0, 2'd2));
    sb.push_back(mk(7'h42, 3'd1, 1'b1, 8'd2, 1'b0, 2'd2));
    sb.push_back(mk(7'h42, 3'd1, 1'b1, 8'd2, 1'b1, 2'd1));
    sb.push_back(mk(7'h42, 3'd1, 1'b1, 8'd2, 1'b0, 2'd1));
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL tmo_enter: got %h want %h", obs, exp_v); end
    tick(15);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL tmo_pending: got %h want %h", obs, exp_v); end
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL tmo_pulse: got %h want %h", obs, exp_v); end
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL tmo_after: got %h want %h", obs, exp_v); end
    bus.ack = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_in_wait();
    bus.ack = 1'b1;
    sb.push_back(mk(7'h42, 3'd1, 1'b1, 8'd2, 1'b0, 2'd2));
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rw_enter: got %h want %h", obs, exp_v); end
    reset = 1'b1;
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd0, 1'b0, 2'd0));
    tick(1);
    reset = 1'b0; bus.ack = 1'b0;
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rw_reset: got %h want %h", obs, exp_v); end
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd0, 1'b0, 2'd0));
    sb.push_back(mk(7'h42, 3'd1, 1'b1, 8'd1, 1'b0, 2'd1));
    tick(5);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL retrip_early: got %h want %h", obs, exp_v); end
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL retrip_latch: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_ack_direct();
    bus.fault_in_b = 7'h7F;
    sb.push_back(mk(7'h42, 3'd1, 1'b1, 8'd1, 1'b0, 2'd1));
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd1, 1'b0, 2'd0));
    tick(4);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL direct_hold: got %h want %h", obs, exp_v); end
    bus.ack = 1'b1;
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL direct_clear: got %h want %h", obs, exp_v); end
    bus.ack = 1'b0;
    tick(1);
  endtask

  task automatic test_ack_armed();
    bus.ack = 1'b1;
    sb.push_back(mk(7'h00, 3'd0, 1'b0, 8'd1, 1'b0, 2'd0));
    tick(2);
    bus.ack = 1'b0;
    tick(1);
    obs = sample(); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL armed_ack: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.fault_in_b = 7'h7F;
    bus.ack = 1'b0;
    test_reset();
    test_debounce();
    test_ack_wait();
    test_simultaneous();
    test_timeout();
    test_reset_in_wait();
    test_ack_direct();
    test_ack_armed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
